// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - operand forwarding, load-use stall and redirect flush control
//
// Purpose: selects forwarded rs1/rs2 operands for the DE stage from the EXE, ACC
// and WB stages, raises a load-use stall, holds a flush window after a redirect
// and counts stall cycles.
//
// Ports:
//   clk, rst_n                      clock (rising edge), async active-low reset
//   instr_de/exe/acc/wb             32-bit instruction per stage
//   valid_de/exe/acc/wb             stage holds a live instruction
//   data_a_de, data_b_de            register-file rs1/rs2 values
//   alu_out_exe, pc_exe             EXE result and PC
//   alu_out_acc, dmem_out_acc,
//   pc_4_acc                        ACC results
//   data_d_wb                       WB write data
//   redirect_exe                    branch/jump resolved in EXE
//   data_a_mgr, data_b_mgr          operands after forwarding
//   hazard_a, hazard_b              operand was forwarded
//   stall, flush                    pipeline control
//   stall_cnt                       saturating stall-cycle counter
module fwd_hazard_unit #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr_de,
    input  logic [31:0]      instr_exe,
    input  logic [31:0]      instr_acc,
    input  logic [31:0]      instr_wb,
    input  logic             valid_de,
    input  logic             valid_exe,
    input  logic             valid_acc,
    input  logic             valid_wb,
    input  logic [XLEN-1:0]  data_a_de,
    input  logic [XLEN-1:0]  data_b_de,
    input  logic [XLEN-1:0]  alu_out_exe,
    input  logic [XLEN-1:0]  pc_exe,
    input  logic [XLEN-1:0]  alu_out_acc,
    input  logic [XLEN-1:0]  dmem_out_acc,
    input  logic [XLEN-1:0]  pc_4_acc,
    input  logic [XLEN-1:0]  data_d_wb,
    input  logic             redirect_exe,
    output logic [XLEN-1:0]  data_a_mgr,
    output logic [XLEN-1:0]  data_b_mgr,
    output logic             hazard_a,
    output logic             hazard_b,
    output logic             stall,
    output logic             flush,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;
    localparam logic [2:0] FCNT_RELOAD = 3'(FLUSH_CYCLES);

    function automatic logic is_writer(input logic [6:0] op);
        return (op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL) || (op == OP_JALR) ||
               (op == OP_LOAD) || (op == OP_OPIMM) || (op == OP_OP);
    endfunction

    function automatic logic is_link(input logic [6:0] op);
        return (op == OP_JAL) || (op == OP_JALR);
    endfunction

    // DE source decode
    logic [6:0] op_de;
    logic [4:0] rs1_de, rs2_de;
    logic       rs1_used, rs2_used;
    assign op_de    = instr_de[6:0];
    assign rs1_de   = instr_de[19:15];
    assign rs2_de   = instr_de[24:20];
    assign rs1_used = !((op_de == OP_LUI) || (op_de == OP_AUIPC) || (op_de == OP_JAL));
    assign rs2_used = (op_de == OP_BRANCH) || (op_de == OP_STORE) || (op_de == OP_OP);

    // Producer decode: a stage is a candidate only if live, a writer and rd != x0
    logic [6:0] op_exe, op_acc, op_wb;
    logic [4:0] rd_exe, rd_acc, rd_wb;
    logic       wr_exe, wr_acc, wr_wb;
    assign op_exe = instr_exe[6:0];
    assign op_acc = instr_acc[6:0];
    assign op_wb  = instr_wb[6:0];
    assign rd_exe = instr_exe[11:7];
    assign rd_acc = instr_acc[11:7];
    assign rd_wb  = instr_wb[11:7];
    assign wr_exe = valid_exe && is_writer(op_exe) && (rd_exe != 5'd0);
    assign wr_acc = valid_acc && is_writer(op_acc) && (rd_acc != 5'd0);
    assign wr_wb  = valid_wb  && is_writer(op_wb)  && (rd_wb  != 5'd0);

    logic [XLEN-1:0] val_exe, val_acc;
    assign val_exe = is_link(op_exe) ? (pc_exe + XLEN'(4)) : alu_out_exe;
    assign val_acc = (op_acc == OP_LOAD) ? dmem_out_acc :
                     is_link(op_acc)     ? pc_4_acc     : alu_out_acc;

    // Priority EXE > ACC > WB, resolved separately per operand
    always_comb begin
        data_a_mgr = data_a_de;
        hazard_a   = 1'b0;
        if (rs1_used && wr_exe && (rd_exe == rs1_de)) begin
            data_a_mgr = val_exe;
            hazard_a   = 1'b1;
        end else if (rs1_used && wr_acc && (rd_acc == rs1_de)) begin
            data_a_mgr = val_acc;
            hazard_a   = 1'b1;
        end else if (rs1_used && wr_wb && (rd_wb == rs1_de)) begin
            data_a_mgr = data_d_wb;
            hazard_a   = 1'b1;
        end
    end

    always_comb begin
        data_b_mgr = data_b_de;
        hazard_b   = 1'b0;
        if (rs2_used && wr_exe && (rd_exe == rs2_de)) begin
            data_b_mgr = val_exe;
            hazard_b   = 1'b1;
        end else if (rs2_used && wr_acc && (rd_acc == rs2_de)) begin
            data_b_mgr = val_acc;
            hazard_b   = 1'b1;
        end else if (rs2_used && wr_wb && (rd_wb == rs2_de)) begin
            data_b_mgr = data_d_wb;
            hazard_b   = 1'b1;
        end
    end

    // Load-use is judged against EXE alone so older matches cannot hide it
    logic load_use;
    assign load_use = valid_de && wr_exe && (op_exe == OP_LOAD) &&
                      ((rs1_used && (rd_exe == rs1_de)) || (rs2_used && (rd_exe == rs2_de)));

    logic [0:0] state_q, state_d;
    logic [2:0] fcnt_q, fcnt_d;

    assign flush = (state_q == ST_FLUSH);
    // The instruction being stalled is about to be killed anyway during a redirect
    assign stall = rst_n && load_use && !flush && !redirect_exe;

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        if (redirect_exe) begin
            state_d = ST_FLUSH;
            fcnt_d  = FCNT_RELOAD;
        end else if (state_q == ST_FLUSH) begin
            fcnt_d = fcnt_q - 3'd1;
            if (fcnt_q <= 3'd1) begin
                state_d = ST_RUN;
                fcnt_d  = 3'd0;
            end
        end
    end

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    assign stall_cnt = stall_cnt_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            fcnt_q      <= 3'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr_de[31:25], instr_de[14:7], instr_exe[31:12],
                                 instr_acc[31:12], instr_wb[31:12]};

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - directed self-checking bench for fwd_hazard_unit
module tb_fwd_hazard_unit;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_OPIMM = 7'b0010011;
    localparam logic [6:0] OP_OP    = 7'b0110011;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [31:0]      instr_de, instr_exe, instr_acc, instr_wb;
    logic             valid_de, valid_exe, valid_acc, valid_wb;
    logic [XLEN-1:0]  data_a_de, data_b_de, alu_out_exe, pc_exe;
    logic [XLEN-1:0]  alu_out_acc, dmem_out_acc, pc_4_acc, data_d_wb;
    logic             redirect_exe;
    logic [XLEN-1:0]  data_a_mgr, data_b_mgr;
    logic             hazard_a, hazard_b, stall, flush;
    logic [CNT_W-1:0] stall_cnt;

    int pass_cnt = 0;
    int total_cnt = 0;

    fwd_hazard_unit #(.XLEN(XLEN), .FLUSH_CYCLES(2), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_de(instr_de), .instr_exe(instr_exe), .instr_acc(instr_acc), .instr_wb(instr_wb),
        .valid_de(valid_de), .valid_exe(valid_exe), .valid_acc(valid_acc), .valid_wb(valid_wb),
        .data_a_de(data_a_de), .data_b_de(data_b_de),
        .alu_out_exe(alu_out_exe), .pc_exe(pc_exe),
        .alu_out_acc(alu_out_acc), .dmem_out_acc(dmem_out_acc), .pc_4_acc(pc_4_acc),
        .data_d_wb(data_d_wb), .redirect_exe(redirect_exe),
        .data_a_mgr(data_a_mgr), .data_b_mgr(data_b_mgr),
        .hazard_a(hazard_a), .hazard_b(hazard_b),
        .stall(stall), .flush(flush), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b0, rd, op};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        instr_de = '0; instr_exe = '0; instr_acc = '0; instr_wb = '0;
        valid_de = 0; valid_exe = 0; valid_acc = 0; valid_wb = 0;
        data_a_de = 32'hAA; data_b_de = 32'hBB;
        alu_out_exe = 32'h1000; pc_exe = 32'h2000;
        alu_out_acc = 32'h3000; dmem_out_acc = 32'h4000; pc_4_acc = 32'h5000;
        data_d_wb = 32'h6000; redirect_exe = 0;
    endtask

    task automatic load_use_inputs();
        instr_exe = enc(OP_LOAD, 5'd7, 5'd2, 5'd0); valid_exe = 1;
        instr_de  = enc(OP_OP, 5'd8, 5'd1, 5'd7);   valid_de  = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        data_a_de = 32'h55;
        #3;
        total_cnt++; if (flush !== 1'b0) $display("FAIL reset_flush: got %b want 0", flush); else pass_cnt++;
        total_cnt++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall); else pass_cnt++;
        total_cnt++; if (stall_cnt !== 4'd0) $display("FAIL reset_cnt: got %0d want 0", stall_cnt); else pass_cnt++;
        total_cnt++; if (data_a_mgr !== 32'h55 || hazard_a !== 1'b0) $display("FAIL reset_passthru: got %h/%b want 00000055/0", data_a_mgr, hazard_a); else pass_cnt++;
        tick();
        rst_n = 1;
        tick();
    endtask

    task automatic test_exe_forward();
        clear_inputs();
        instr_exe = enc(OP_OPIMM, 5'd5, 5'd0, 5'd0); valid_exe = 1; alu_out_exe = 32'h11;
        instr_acc = enc(OP_OP, 5'd5, 5'd1, 5'd2);    valid_acc = 1; alu_out_acc = 32'h22;
        instr_wb  = enc(OP_OPIMM, 5'd5, 5'd0, 5'd0); valid_wb  = 1; data_d_wb   = 32'h33;
        instr_de  = enc(OP_OP, 5'd6, 5'd5, 5'd5);    valid_de  = 1;
        #1;
        total_cnt++; if (data_a_mgr !== 32'h11 || data_b_mgr !== 32'h11) $display("FAIL exe_fwd_data: got %h/%h want 11/11", data_a_mgr, data_b_mgr); else pass_cnt++;
        total_cnt++; if (hazard_a !== 1'b1 || hazard_b !== 1'b1 || stall !== 1'b0) $display("FAIL exe_fwd_flags: got ha=%b hb=%b st=%b want 1 1 0", hazard_a, hazard_b, stall); else pass_cnt++;
        valid_exe = 0;
        #1;
        total_cnt++; if (data_a_mgr !== 32'h22 || data_b_mgr !== 32'h22) $display("FAIL acc_fwd_data: got %h/%h want 22/22", data_a_mgr, data_b_mgr); else pass_cnt++;
        instr_acc = enc(OP_LOAD, 5'd5, 5'd1, 5'd0);
        #1;
        total_cnt++; if (data_a_mgr !== 32'h4000) $display("FAIL acc_load_fwd: got %h want 00004000", data_a_mgr); else pass_cnt++;
        valid_acc = 0;
        #1;
        total_cnt++; if (data_b_mgr !== 32'h33 || hazard_b !== 1'b1) $display("FAIL wb_fwd: got %h/%b want 33/1", data_b_mgr, hazard_b); else pass_cnt++;
        tick();
    endtask

    task automatic test_x0_valid();
        clear_inputs();
        instr_exe = enc(OP_OPIMM, 5'd0, 5'd0, 5'd0); valid_exe = 1; alu_out_exe = 32'h77;
        instr_de  = enc(OP_OP, 5'd6, 5'd0, 5'd0);    valid_de  = 1;
        #1;
        total_cnt++; if (hazard_a !== 1'b0 || data_a_mgr !== 32'hAA) $display("FAIL x0_no_fwd: got %h/%b want aa/0", data_a_mgr, hazard_a); else pass_cnt++;
        instr_exe = enc(OP_OPIMM, 5'd5, 5'd0, 5'd0); valid_exe = 0;
        instr_de  = enc(OP_OP, 5'd6, 5'd5, 5'd5);
        #1;
        total_cnt++; if (hazard_a !== 1'b0 || data_a_mgr !== 32'hAA) $display("FAIL invalid_no_fwd: got %h/%b want aa/0", data_a_mgr, hazard_a); else pass_cnt++;
        valid_exe = 1;
        instr_de  = enc(OP_OPIMM, 5'd6, 5'd1, 5'd5);
        #1;
        total_cnt++; if (hazard_b !== 1'b0 || data_b_mgr !== 32'hBB) $display("FAIL rs2_unused: got %h/%b want bb/0", data_b_mgr, hazard_b); else pass_cnt++;
        tick();
    endtask

    task automatic test_jal_forward();
        clear_inputs();
        instr_exe = enc(OP_JAL, 5'd1, 5'd0, 5'd0); valid_exe = 1;
        pc_exe = 32'h100; alu_out_exe = 32'h999;
        instr_de  = enc(OP_OPIMM, 5'd2, 5'd1, 5'd0); valid_de = 1;
        #1;
        total_cnt++; if (data_a_mgr !== 32'h104) $display("FAIL jal_exe_fwd: got %h want 00000104", data_a_mgr); else pass_cnt++;
        pc_exe = 32'hFFFF_FFFC;
        #1;
        total_cnt++; if (data_a_mgr !== 32'h0) $display("FAIL jal_pc_wrap: got %h want 00000000", data_a_mgr); else pass_cnt++;
        valid_exe = 0;
        instr_acc = enc(OP_JAL, 5'd1, 5'd0, 5'd0); valid_acc = 1; pc_4_acc = 32'h208;
        #1;
        total_cnt++; if (data_a_mgr !== 32'h208) $display("FAIL jal_acc_fwd: got %h want 00000208", data_a_mgr); else pass_cnt++;
        tick();
    endtask

    task automatic test_load_use();
        clear_inputs();
        load_use_inputs();
        valid_de = 0;
        #1;
        total_cnt++; if (stall !== 1'b0) $display("FAIL lu_de_invalid: got %b want 0", stall); else pass_cnt++;
        valid_de = 1;
        instr_acc = enc(OP_OPIMM, 5'd7, 5'd0, 5'd0); valid_acc = 1;
        #1;
        total_cnt++; if (stall !== 1'b1) $display("FAIL lu_stall: got %b want 1", stall); else pass_cnt++;
        tick();
        total_cnt++; if (stall_cnt !== 4'd1) $display("FAIL lu_count: got %0d want 1", stall_cnt); else pass_cnt++;
        valid_exe = 0;
        instr_acc = enc(OP_LOAD, 5'd7, 5'd2, 5'd0); valid_acc = 1; dmem_out_acc = 32'hDEAD;
        #1;
        total_cnt++; if (data_b_mgr !== 32'hDEAD || hazard_b !== 1'b1) $display("FAIL lu_acc_data: got %h/%b want dead/1", data_b_mgr, hazard_b); else pass_cnt++;
        total_cnt++; if (stall !== 1'b0 || data_a_mgr !== 32'hAA) $display("FAIL lu_released: got st=%b a=%h want 0/aa", stall, data_a_mgr); else pass_cnt++;
        valid_de = 0;
        tick();
    endtask

    task automatic test_flush_timing();
        clear_inputs();
        redirect_exe = 1;
        tick();
        redirect_exe = 0;
        total_cnt++; if (flush !== 1'b1) $display("FAIL single_flush_c1: got %b want 1", flush); else pass_cnt++;
        tick();
        total_cnt++; if (flush !== 1'b1) $display("FAIL single_flush_c2: got %b want 1", flush); else pass_cnt++;
        tick();
        total_cnt++; if (flush !== 1'b0) $display("FAIL single_flush_end: got %b want 0", flush); else pass_cnt++;
        // cycle 10: redirect with a load-use present
        load_use_inputs();
        redirect_exe = 1;
        #1;
        total_cnt++; if (stall !== 1'b0 || flush !== 1'b0) $display("FAIL c10: got st=%b fl=%b want 0 0", stall, flush); else pass_cnt++;
        tick();
        #1;
        total_cnt++; if (flush !== 1'b1 || stall !== 1'b0) $display("FAIL c11: got fl=%b st=%b want 1 0", flush, stall); else pass_cnt++;
        tick();
        redirect_exe = 0;
        #1;
        total_cnt++; if (flush !== 1'b1 || stall !== 1'b0) $display("FAIL c12: got fl=%b st=%b want 1 0", flush, stall); else pass_cnt++;
        tick();
        total_cnt++; if (flush !== 1'b1 || stall !== 1'b0) $display("FAIL c13: got fl=%b st=%b want 1 0", flush, stall); else pass_cnt++;
        tick();
        total_cnt++; if (flush !== 1'b0 || stall !== 1'b1) $display("FAIL c14: got fl=%b st=%b want 0 1", flush, stall); else pass_cnt++;
        valid_de = 0;
        #1;
        total_cnt++; if (stall_cnt !== 4'd1) $display("FAIL flush_cnt_hold: got %0d want 1", stall_cnt); else pass_cnt++;
        tick();
    endtask

    task automatic test_saturation();
        clear_inputs();
        load_use_inputs();
        for (int i = 0; i < 13; i++) tick();
        total_cnt++; if (stall_cnt !== 4'd14) $display("FAIL sat_mid: got %0d want 14", stall_cnt); else pass_cnt++;
        for (int i = 0; i < 7; i++) tick();
        total_cnt++; if (stall_cnt !== 4'd15) $display("FAIL sat_top: got %0d want 15", stall_cnt); else pass_cnt++;
    endtask

    task automatic test_reset_mid_flush();
        clear_inputs();
        load_use_inputs();
        alu_out_exe = 32'h40;
        redirect_exe = 1;
        tick();
        redirect_exe = 0;
        total_cnt++; if (flush !== 1'b1) $display("FAIL rmf_flush_on: got %b want 1", flush); else pass_cnt++;
        #1;
        rst_n = 0;
        #1;
        total_cnt++; if (flush !== 1'b0 || stall_cnt !== 4'd0) $display("FAIL rmf_async: got fl=%b cnt=%0d want 0 0", flush, stall_cnt); else pass_cnt++;
        total_cnt++; if (stall !== 1'b0 || data_b_mgr !== 32'h40 || hazard_b !== 1'b1) $display("FAIL rmf_comb: got st=%b b=%h hb=%b want 0 40 1", stall, data_b_mgr, hazard_b); else pass_cnt++;
        valid_de = 0;
        tick();
        rst_n = 1;
        tick();
        total_cnt++; if (flush !== 1'b0 || stall_cnt !== 4'd0) $display("FAIL rmf_resume: got fl=%b cnt=%0d want 0 0", flush, stall_cnt); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_exe_forward();
        test_x0_valid();
        test_jal_forward();
        test_load_use();
        test_flush_timing();
        test_saturation();
        test_reset_mid_flush();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
